// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch sequencer: FSM states, key indices and prescaler helper.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StLap   = 3'd3,
    StDone  = 3'd4
  } sw_state_e;

  // Key slots in the press vector; priority when coincident is clr > run > lap.
  localparam int unsigned KeyRun = 0;
  localparam int unsigned KeyClr = 1;
  localparam int unsigned KeyLap = 2;

  function automatic int unsigned prescale_div(input int unsigned clk_hz,
                                               input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-key and counter-side signal bundle of the stopwatch sequencer.
interface stopwatch_ctrl_if;
  logic        key_run_n;
  logic        key_clr_n;
  logic        key_lap_n;
  logic [15:0] count_val;
  logic        count_en;
  logic        count_clr;
  logic        disp_hold;
  logic [2:0]  state;

  modport master (
    output key_run_n, key_clr_n, key_lap_n, count_val,
    input  count_en, count_clr, disp_hold, state
  );

  modport slave (
    input  key_run_n, key_clr_n, key_lap_n, count_val,
    output count_en, count_clr, disp_hold, state
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stable-level debounce counter and one-cycle press (1->0) event.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q, stable_q, press_q;
  logic [CntW-1:0] cnt_q;
  logic            settle;

  // Level differs from the accepted one for the final required cycle.
  assign settle = (sync2_q != stable_q) && (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press_q <= settle & ~sync2_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (settle) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer with tick prescaler and registered counter strobes.
// Define STOPWATCH_AUTO_WRAP_EN to wrap the counter at MAX_COUNT instead of stopping in DONE.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [15:0] MAX_COUNT       = 16'd65535
) (
  input logic              CLOCK_50,
  input logic              reset_n,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned Div  = prescale_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;

  logic [2:0] press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
    .clk(CLOCK_50), .reset_n(reset_n), .key_n(bus.key_run_n), .press(press[KeyRun])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
    .clk(CLOCK_50), .reset_n(reset_n), .key_n(bus.key_clr_n), .press(press[KeyClr])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
    .clk(CLOCK_50), .reset_n(reset_n), .key_n(bus.key_lap_n), .press(press[KeyLap])
  );

  sw_state_e       state_q, state_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            en_q, en_d, clr_q, clr_d, hold_q, hold_d;
  logic            running, tick, at_max, done_hit;

  assign running = (state_q == StRun) || (state_q == StLap);
  assign tick    = running && (presc_q == PreW'(Div - 1));
  assign at_max  = tick && (bus.count_val == MAX_COUNT);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    en_d     = 1'b0;
    clr_d    = 1'b0;
    done_hit = 1'b0;
    if (running) presc_d = tick ? '0 : presc_q + 1'b1;

    if (press[KeyClr]) begin
      state_d = StIdle;
      clr_d   = 1'b1;
      hold_d  = 1'b0;
    end else begin
      en_d = tick && !at_max;
`ifdef STOPWATCH_AUTO_WRAP_EN
      clr_d = at_max;
`else
      done_hit = at_max;
`endif
      if (done_hit) begin
        state_d = StDone;
        hold_d  = 1'b0;
      end else begin
        case (state_q)
          StIdle: if (press[KeyRun]) state_d = StRun;
          StRun: begin
            if (press[KeyRun]) begin
              state_d = StPause;
              hold_d  = 1'b0;
            end else if (press[KeyLap]) begin
              state_d = StLap;
              hold_d  = 1'b1;
            end
          end
          StLap: begin
            // Pausing from LAP keeps the lapped value on the display.
            if (press[KeyRun]) begin
              state_d = StPause;
            end else if (press[KeyLap]) begin
              state_d = StRun;
              hold_d  = 1'b0;
            end
          end
          StPause: begin
            if (press[KeyRun]) begin
              state_d = StRun;
              hold_d  = 1'b0;
            end else if (press[KeyLap]) begin
              hold_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    if ((state_d == StIdle) || (state_d == StDone)) presc_d = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.count_en  = en_q;
  assign bus.count_clr = clr_q;
  assign bus.disp_hold = hold_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random key traffic
// compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned ClkHz  = 1000;
  localparam int unsigned TickHz = 100;
  localparam int unsigned Deb    = 4;
  localparam logic [15:0] MaxCnt = 16'd5;
  localparam int Div = ClkHz / TickHz;
  localparam int SIdle = 0, SRun = 1, SPause = 2, SLap = 3, SDone = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  key_n = 3'b111;  // [0] run, [1] clr, [2] lap
  logic        use_ovr = 1'b1;
  logic [15:0] ovr_val = '0;
  logic [15:0] cnt_model = '0;

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;
  int hold_cnt[3] = '{0, 0, 0};

  stopwatch_ctrl_if sw_if ();
  assign sw_if.key_run_n = key_n[0];
  assign sw_if.key_clr_n = key_n[1];
  assign sw_if.key_lap_n = key_n[2];
  assign sw_if.count_val = use_ovr ? ovr_val : cnt_model;

  stopwatch_ctrl #(
    .CLK_HZ(ClkHz), .TICK_HZ(TickHz), .DEBOUNCE_CYCLES(Deb), .MAX_COUNT(MaxCnt)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .bus     (sw_if.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: state after each rising edge.
  int       m_state, m_presc;
  bit       m_en, m_clr, m_hold;
  bit [2:0] ev_pend, sy1, sy2, seen, acc;
  int       run_len[3];

  always @(posedge clk) begin
    bit tick, at_max, to_done;
    bit [2:0] ev_new;
    if (!reset_n) begin
      m_state = SIdle; m_presc = 0; m_en = 0; m_clr = 0; m_hold = 0;
      ev_pend = '0; sy1 = '1; sy2 = '1; seen = '1; acc = '1;
      run_len = '{0, 0, 0};
      cnt_model <= '0;
    end else begin
      if (m_clr) cnt_model <= '0;
      else if (m_en) cnt_model <= cnt_model + 16'd1;
      tick   = (m_state == SRun || m_state == SLap) && (m_presc == Div - 1);
      at_max = tick && (sw_if.count_val == MaxCnt);
      m_en = 0; m_clr = 0; to_done = 0;
      if (m_state == SRun || m_state == SLap) m_presc = (m_presc + 1) % Div;
      if (ev_pend[1]) begin
        m_state = SIdle; m_clr = 1; m_hold = 0;
      end else begin
        m_en = tick && !at_max;
`ifdef STOPWATCH_AUTO_WRAP_EN
        m_clr = at_max;
`else
        to_done = at_max;
`endif
        if (to_done) begin
          m_state = SDone; m_hold = 0;
        end else if (ev_pend[0]) begin
          case (m_state)
            SIdle:  m_state = SRun;
            SRun:   begin m_state = SPause; m_hold = 0; end
            SLap:   m_state = SPause;
            SPause: begin m_state = SRun; m_hold = 0; end
            default: ;
          endcase
        end else if (ev_pend[2]) begin
          case (m_state)
            SRun:   begin m_state = SLap; m_hold = 1; end
            SLap:   begin m_state = SRun; m_hold = 0; end
            SPause: m_hold = 0;
            default: ;
          endcase
        end
      end
      if (m_state == SIdle || m_state == SDone) m_presc = 0;
      // A key is accepted once its synchronized level has held for Deb cycles.
      for (int k = 0; k < 3; k++) begin
        ev_new[k] = 0;
        if (sy2[k] == seen[k]) run_len[k]++;
        else run_len[k] = 1;
        seen[k] = sy2[k];
        if (sy2[k] != acc[k] && run_len[k] >= Deb) begin
          acc[k] = sy2[k];
          ev_new[k] = ~sy2[k];
        end
        sy2[k] = sy1[k];
        sy1[k] = key_n[k];
      end
      ev_pend = ev_new;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (sw_if.state !== 3'(m_state) || sw_if.count_en !== m_en ||
          sw_if.count_clr !== m_clr || sw_if.disp_hold !== m_hold) begin
        errors++;
        $display("FAIL model t=%0t state %0d want %0d en %0b want %0b clr %0b want %0b hold %0b want %0b",
                 $time, sw_if.state, m_state, sw_if.count_en, m_en, sw_if.count_clr, m_clr,
                 sw_if.disp_hold, m_hold);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (hold_cnt[k] > 0) begin
        hold_cnt[k]--;
        if (hold_cnt[k] == 0) key_n[k] = 1'b1;
      end
    end
  endtask

  task automatic press(input int k, input int hold);
    key_n[k] = 1'b0;
    hold_cnt[k] = hold;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, en_a, en_b, st24, en_cnt;

    // Reset with all keys held low.
    key_n = 3'b000;
    reset_n = 1'b0;
    step();
    model_live = 1'b1;
    step();
    check("reset_state", int'(sw_if.state), SIdle);
    check("reset_en", int'(sw_if.count_en), 0);
    check("reset_clr", int'(sw_if.count_clr), 0);
    check("reset_hold", int'(sw_if.disp_hold), 0);
    key_n = 3'b111;
    step();
    reset_n = 1'b1;
    repeat (10) step();
    check("no_event_after_reset", int'(sw_if.state), SIdle);

    // Bounced run press, then a second run press timed to land 25 cycles into RUN.
    key_n[0] = 1'b0; step();
    key_n[0] = 1'b1; step();
    key_n[0] = 1'b0; step();
    press(0, 12);
    n = 0;
    while (sw_if.state != 3'(SRun) && n < 40) begin step(); n++; end
    check("run_entry", int'(sw_if.state), SRun);
    en_a = -1; en_b = -1; st24 = -1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (sw_if.count_en) begin
        if (en_a < 0) en_a = i;
        else if (en_b < 0) en_b = i;
      end
      if (i == 18) press(0, 6);
      if (i == 24) st24 = int'(sw_if.state);
    end
    check("first_tick", en_a, 10);
    check("second_tick", en_b, 20);
    check("run_before_pause", st24, SRun);
    check("pause_state", int'(sw_if.state), SPause);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); en_cnt += int'(sw_if.count_en); end
    check("pause_no_tick", en_cnt, 0);

    // Resume: prescaler was frozen at 5, so the next tick is 5 cycles out.
    press(0, 8);
    n = 0;
    while (sw_if.state != 3'(SRun) && n < 30) begin step(); n++; end
    check("resume_entry", int'(sw_if.state), SRun);
    c = 0;
    do begin step(); c++; end while (!sw_if.count_en && c < 20);
    check("resume_tick", c, 5);

    // Lap holds display while counting continues; second lap releases it.
    repeat (4) step();
    press(2, 8);
    n = 0;
    while (!sw_if.disp_hold && n < 30) begin step(); n++; end
    check("lap_state", int'(sw_if.state), SLap);
    check("lap_hold", int'(sw_if.disp_hold), 1);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); en_cnt += int'(sw_if.count_en); end
    check("lap_ticks", en_cnt, 1);
    repeat (6) step();
    press(2, 8);
    n = 0;
    while (sw_if.state != 3'(SRun) && n < 30) begin step(); n++; end
    check("lap_release_state", int'(sw_if.state), SRun);
    check("lap_release_hold", int'(sw_if.disp_hold), 0);

    // Clear and run together: clear wins.
    repeat (12) step();
    press(1, 8);
    press(0, 8);
    n = 0;
    while (!sw_if.count_clr && n < 30) begin step(); n++; end
    check("clr_strobe", int'(sw_if.count_clr), 1);
    check("clr_state", int'(sw_if.state), SIdle);
    check("clr_no_en", int'(sw_if.count_en), 0);
    step();
    check("clr_one_cycle", int'(sw_if.count_clr), 0);
    repeat (15) step();
    check("no_run_after_clr", int'(sw_if.state), SIdle);

    // Terminal count handling with the counter stand-in driving count_val.
    use_ovr = 1'b0;
    press(0, 8);
    n = 0;
    while (sw_if.state != 3'(SRun) && n < 30) begin step(); n++; end
    check("max_run_entry", int'(sw_if.state), SRun);
    en_cnt = 0;
    c = 0;
`ifdef STOPWATCH_AUTO_WRAP_EN
    do begin step(); c++; en_cnt += int'(sw_if.count_en); end
    while (!sw_if.count_clr && c < 80);
    check("wrap_cycle", c, 60);
    check("wrap_state", int'(sw_if.state), SRun);
    check("wrap_no_en", int'(sw_if.count_en), 0);
    check("wrap_en_count", en_cnt, 5);
`else
    do begin step(); c++; en_cnt += int'(sw_if.count_en); end
    while (sw_if.state != 3'(SDone) && c < 80);
    check("done_cycle", c, 60);
    check("done_state", int'(sw_if.state), SDone);
    check("done_no_en", int'(sw_if.count_en), 0);
    check("done_en_count", en_cnt, 5);
    press(0, 8);
    repeat (20) step();
    check("done_ignores_run", int'(sw_if.state), SDone);
`endif
    press(1, 8);
    n = 0;
    while (sw_if.state != 3'(SIdle) && n < 30) begin step(); n++; end
    check("clr_to_idle", int'(sw_if.state), SIdle);

    // Random traffic: short holds act as bounces, count_val sometimes forced near max.
    for (int i = 0; i < 4000; i++) begin
      int k;
      step();
      if ($urandom_range(0, 29) == 0) begin
        k = int'($urandom_range(0, 2));
        if (hold_cnt[k] == 0 && (k != 1 || $urandom_range(0, 3) == 0))
          press(k, int'($urandom_range(1, 14)));
      end
      if ($urandom_range(0, 99) == 0) begin
        use_ovr = 1'($urandom_range(0, 1));
        ovr_val = 16'($urandom_range(3, 5));
      end
      if ($urandom_range(0, 1499) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
